// File: rtl/proc_pkg.sv
// Shared processor constants and helpers for the register file.
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    // One-hot write decode; all zeros when the write is disabled.
    function automatic logic [NUM_REGS-1:0] onehot_decode(
        input logic [ADDR_W-1:0] addr,
        input logic              en
    );
        logic [NUM_REGS-1:0] sel;
        sel = {NUM_REGS{1'b0}};
        if (en) begin
            sel[addr] = 1'b1;
        end else begin
            sel = {NUM_REGS{1'b0}};
        end
        return sel;
    endfunction

endpackage

// File: rtl/register_file_reg16.sv
// One data-width register with asynchronous active-low clear and load enable.
module reg16
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear immediately on reset; capture d on the edge when load is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {DATA_W{1'b0}};
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/register_file.sv
// 16 x 16 register file: five combinational read ports, one synchronous write port.
module register_file
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] D_ReadReg1RT,
    output logic [DATA_W-1:0] D_ReadReg2RT,
    output logic [DATA_W-1:0] D_Offset,
    output logic [DATA_W-1:0] D_RegSW,
    output logic [DATA_W-1:0] D_BT,
    input  logic [DATA_W-1:0] D_MDR_IN,
    input  logic [DATA_W-1:0] D_ALU_IN,
    input  logic [ADDR_W-1:0] A_ReadReg1RT,
    input  logic [ADDR_W-1:0] A_ReadReg2RT,
    input  logic [ADDR_W-1:0] A_Offset,
    input  logic [ADDR_W-1:0] A_RegSWLW,
    input  logic [ADDR_W-1:0] A_WriteRegRT_BT,
    input  logic              C_RegDstWrite,
    input  logic              C_RegWrite,
    input  logic              C_MemToReg
);

    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] wr_sel;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // Select write destination and data source, then decode to a one-hot load.
    always_comb begin
        wr_addr = A_RegSWLW;
        wr_data = D_ALU_IN;
        if (C_RegDstWrite) begin
            wr_addr = A_WriteRegRT_BT;
        end else begin
            wr_addr = A_RegSWLW;
        end
        if (C_MemToReg) begin
            wr_data = D_MDR_IN;
        end else begin
            wr_data = D_ALU_IN;
        end
        wr_sel = onehot_decode(wr_addr, C_RegWrite);
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        reg16 u_reg (
            .clk  (clk),
            .rst  (rst),
            .load (wr_sel[i]),
            .d    (wr_data),
            .q    (regs[i])
        );
    end

    // Read muxes are unbypassed: a register being written shows its old value until the edge.
    always_comb begin
        D_ReadReg1RT = regs[A_ReadReg1RT];
        D_ReadReg2RT = regs[A_ReadReg2RT];
        D_Offset     = regs[A_Offset];
        D_RegSW      = regs[A_RegSWLW];
        D_BT         = regs[A_WriteRegRT_BT];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table, read-during-write, random vs model, reset.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [15:0] D_ReadReg1RT, D_ReadReg2RT, D_Offset, D_RegSW, D_BT;
    logic [15:0] D_MDR_IN, D_ALU_IN;
    logic [3:0]  A_ReadReg1RT, A_ReadReg2RT, A_Offset, A_RegSWLW, A_WriteRegRT_BT;
    logic        C_RegDstWrite, C_RegWrite, C_MemToReg;

    int compared   = 0;
    int mismatched = 0;
    logic [15:0] model [16];

    register_file dut (
        .clk             (clk),
        .rst             (rst),
        .D_ReadReg1RT    (D_ReadReg1RT),
        .D_ReadReg2RT    (D_ReadReg2RT),
        .D_Offset        (D_Offset),
        .D_RegSW         (D_RegSW),
        .D_BT            (D_BT),
        .D_MDR_IN        (D_MDR_IN),
        .D_ALU_IN        (D_ALU_IN),
        .A_ReadReg1RT    (A_ReadReg1RT),
        .A_ReadReg2RT    (A_ReadReg2RT),
        .A_Offset        (A_Offset),
        .A_RegSWLW       (A_RegSWLW),
        .A_WriteRegRT_BT (A_WriteRegRT_BT),
        .C_RegDstWrite   (C_RegDstWrite),
        .C_RegWrite      (C_RegWrite),
        .C_MemToReg      (C_MemToReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we, dst, m2r;
        logic [3:0]  a_wbt, a_swlw, r1, r2, off;
        logic [15:0] mdr, alu;
        logic [15:0] e_r1, e_r2, e_off, e_sw, e_bt;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic dst, input logic m2r,
                         input logic [3:0] a_wbt, input logic [3:0] a_swlw,
                         input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] off,
                         input logic [15:0] mdr, input logic [15:0] alu);
        C_RegWrite = we; C_RegDstWrite = dst; C_MemToReg = m2r;
        A_WriteRegRT_BT = a_wbt; A_RegSWLW = a_swlw;
        A_ReadReg1RT = r1; A_ReadReg2RT = r2; A_Offset = off;
        D_MDR_IN = mdr; D_ALU_IN = alu;
    endtask

    // Architectural effect of one clock edge with rst high.
    task automatic model_edge();
        if (C_RegWrite)
            model[C_RegDstWrite ? A_WriteRegRT_BT : A_RegSWLW] = C_MemToReg ? D_MDR_IN : D_ALU_IN;
    endtask

    task automatic check_model(input string tag);
        check({tag, " r1"},  D_ReadReg1RT, model[A_ReadReg1RT]);
        check({tag, " r2"},  D_ReadReg2RT, model[A_ReadReg2RT]);
        check({tag, " off"}, D_Offset,     model[A_Offset]);
        check({tag, " sw"},  D_RegSW,      model[A_RegSWLW]);
        check({tag, " bt"},  D_BT,         model[A_WriteRegRT_BT]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " r1"},  D_ReadReg1RT, 16'h0000);
        check({tag, " r2"},  D_ReadReg2RT, 16'h0000);
        check({tag, " off"}, D_Offset,     16'h0000);
        check({tag, " sw"},  D_RegSW,      16'h0000);
        check({tag, " bt"},  D_BT,         16'h0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        //        we    dst   m2r   wbt    swlw   r1     r2     off    mdr       alu       e_r1      e_r2      e_off     e_sw      e_bt
        vecs[0] = {1'b1, 1'b1, 1'b0, 4'd3,  4'd0,  4'd3,  4'd0,  4'd0,  16'hFFFF, 16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5};
        vecs[1] = {1'b1, 1'b0, 1'b1, 4'd3,  4'd7,  4'd3,  4'd7,  4'd7,  16'h1234, 16'hDEAD, 16'hA5A5, 16'h1234, 16'h1234, 16'h1234, 16'hA5A5};
        vecs[2] = {1'b0, 1'b1, 1'b1, 4'd7,  4'd3,  4'd7,  4'd7,  4'd7,  16'hBEEF, 16'hCAFE, 16'h1234, 16'h1234, 16'h1234, 16'hA5A5, 16'h1234};
        vecs[3] = {1'b1, 1'b1, 1'b0, 4'd15, 4'd7,  4'd15, 4'd3,  4'd7,  16'h0000, 16'hFFFF, 16'hFFFF, 16'hA5A5, 16'h1234, 16'h1234, 16'hFFFF};
        vecs[4] = {1'b1, 1'b0, 1'b0, 4'd15, 4'd0,  4'd0,  4'd15, 4'd3,  16'h9999, 16'h0001, 16'h0001, 16'hFFFF, 16'hA5A5, 16'h0001, 16'hFFFF};

        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222);
        #2;
        check_all_zero("reset_initial");
        @(negedge clk);
        rst = 1'b1;

        // Directed table: inputs applied at negedge, outputs checked after the edge.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].we, vecs[i].dst, vecs[i].m2r, vecs[i].a_wbt, vecs[i].a_swlw,
                  vecs[i].r1, vecs[i].r2, vecs[i].off, vecs[i].mdr, vecs[i].alu);
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("vec%0d r1", i),  D_ReadReg1RT, vecs[i].e_r1);
            check($sformatf("vec%0d r2", i),  D_ReadReg2RT, vecs[i].e_r2);
            check($sformatf("vec%0d off", i), D_Offset,     vecs[i].e_off);
            check($sformatf("vec%0d sw", i),  D_RegSW,      vecs[i].e_sw);
            check($sformatf("vec%0d bt", i),  D_BT,         vecs[i].e_bt);
            @(negedge clk);
        end

        // Read-during-write: old value before the edge, new value after.
        drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd7, 4'd7, 4'd3, 4'd0, 16'h0000, 16'h5555);
        #1;
        check("rdw_before", D_ReadReg2RT, 16'hA5A5);
        @(posedge clk);
        model_edge();
        #1;
        check("rdw_after", D_ReadReg2RT, 16'h5555);
        @(negedge clk);

        // Randomized traffic against the array model.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
            #1;
            check_model($sformatf("rand%0d pre", n));
            @(posedge clk);
            model_edge();
            #1;
            check_model($sformatf("rand%0d post", n));
            @(negedge clk);
        end

        // Mid-run reset: immediate clear, and a write during reset is ignored.
        drive(1'b1, 1'b1, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 16'h7777, 16'h7777);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(posedge clk);
        #1;
        check_all_zero("reset_write_ignored");
        @(negedge clk);
        rst = 1'b1;
        C_RegWrite = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 1'b0, 1'b0, 4'(a), 4'(a), 4'(a), 4'(a), 4'(a), 16'hAAAA, 16'h5555);
            #1;
            check_model($sformatf("post_reset addr%0d", a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
